// File: rtl/tileram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tileram_slot_arbiter
// Purpose  : HSYNC-aligned 8-slot time-division arbiter sharing one 8Kx8 tile
//            RAM between two layer fetch engines and the CPU bus.
// Options  : TILERAM_VBLANK_CPU_EN - during VBLANK every slot is a CPU slot.
// Revision : 1.0  initial release
// ============================================================================
module tileram_slot_arbiter #(
  parameter logic HSYNC_ACTIVE   = 1'b0,
  parameter int   CPU_FIRST_SLOT = 4
) (
  input  logic        CLK_6M,
  input  logic        rst,
  input  logic        HSYNC,
  input  logic        VBLANK,
  input  logic [12:0] l0_addr,
  input  logic [12:0] l1_addr,
  output logic [15:0] l0_data,
  output logic        l0_valid,
  output logic [15:0] l1_data,
  output logic        l1_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] RA,
  output logic        RWE,
  output logic        ROE,
  output logic [7:0]  RD_out,
  output logic        RD_oe,
  input  logic [7:0]  RD_in
);
  localparam logic [2:0] c_cpu_first = 3'(CPU_FIRST_SLOT);

  typedef enum logic [2:0] {
    ACC_IDLE   = 3'd0,
    ACC_L0_LO  = 3'd1,
    ACC_L0_HI  = 3'd2,
    ACC_L1_LO  = 3'd3,
    ACC_L1_HI  = 3'd4,
    ACC_CPU_RD = 3'd5,
    ACC_CPU_WR = 3'd6
  } acc_t;

  logic [2:0]  r_slot;
  logic [2:0]  w_slot_nxt;
  logic        r_started;
  logic        r_hsync;
  logic        w_hs_edge;
  logic        w_all_cpu;
  logic        w_cpu_slot;
  logic        w_cpu_busy;
  acc_t        r_acc;
  acc_t        w_acc_nxt;
  logic [12:0] w_ra_nxt;
  logic [11:0] r_l0_word;
  logic [11:0] r_l1_word;
  logic [7:0]  r_l0_lo;
  logic [7:0]  r_l1_lo;
  logic        w_unused;

  assign w_unused = ^{l0_addr[0], l1_addr[0], VBLANK};

`ifdef TILERAM_VBLANK_CPU_EN
  assign w_all_cpu = VBLANK;
`else
  assign w_all_cpu = 1'b0;
`endif

  always_comb begin
    w_hs_edge  = (HSYNC == HSYNC_ACTIVE) && (r_hsync != HSYNC_ACTIVE);
    w_slot_nxt = (!r_started || w_hs_edge) ? 3'd0 : r_slot + 3'd1;
    w_cpu_slot = w_all_cpu || (w_slot_nxt >= c_cpu_first);
    // A CPU access finishing at this edge acks now; its request is still up.
    w_cpu_busy = (r_acc == ACC_CPU_RD) || (r_acc == ACC_CPU_WR);
    w_acc_nxt  = ACC_IDLE;
    w_ra_nxt   = RA;
    if (w_cpu_slot) begin
      if (cpu_req && !w_cpu_busy) begin
        w_acc_nxt = cpu_we ? ACC_CPU_WR : ACC_CPU_RD;
        w_ra_nxt  = cpu_addr;
      end
    end else begin
      case (w_slot_nxt)
        3'd0: begin w_acc_nxt = ACC_L0_LO; w_ra_nxt = {l0_addr[12:1], 1'b0}; end
        3'd1: begin w_acc_nxt = ACC_L0_HI; w_ra_nxt = {r_l0_word, 1'b1}; end
        3'd2: begin w_acc_nxt = ACC_L1_LO; w_ra_nxt = {l1_addr[12:1], 1'b0}; end
        3'd3: begin w_acc_nxt = ACC_L1_HI; w_ra_nxt = {r_l1_word, 1'b1}; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_6M) r_hsync <= HSYNC;

  always_ff @(posedge CLK_6M) begin
    if (!rst) begin
      r_started <= 1'b0;
      r_slot    <= 3'd0;
      r_acc     <= ACC_IDLE;
      r_l0_word <= 12'd0;
      r_l1_word <= 12'd0;
      r_l0_lo   <= 8'd0;
      r_l1_lo   <= 8'd0;
      RA        <= 13'd0;
      RWE       <= 1'b1;
      ROE       <= 1'b1;
      RD_oe     <= 1'b0;
      RD_out    <= 8'd0;
      cpu_rdata <= 8'd0;
      cpu_ack   <= 1'b0;
      l0_data   <= 16'd0;
      l0_valid  <= 1'b0;
      l1_data   <= 16'd0;
      l1_valid  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_slot    <= w_slot_nxt;
      r_acc     <= w_acc_nxt;
      RA        <= w_ra_nxt;
      ROE       <= (w_acc_nxt == ACC_IDLE) || (w_acc_nxt == ACC_CPU_WR);
      RWE       <= (w_acc_nxt != ACC_CPU_WR);
      RD_oe     <= (w_acc_nxt == ACC_CPU_WR);
      if (w_acc_nxt == ACC_CPU_WR) RD_out <= cpu_wdata;
      if (w_acc_nxt == ACC_L0_LO) r_l0_word <= l0_addr[12:1];
      if (w_acc_nxt == ACC_L1_LO) r_l1_word <= l1_addr[12:1];

      // Completion side: data returned by the slot that ends at this edge.
      l0_valid <= 1'b0;
      l1_valid <= 1'b0;
      cpu_ack  <= 1'b0;
      case (r_acc)
        ACC_L0_LO:  r_l0_lo <= RD_in;
        ACC_L0_HI:  begin l0_data <= {RD_in, r_l0_lo}; l0_valid <= 1'b1; end
        ACC_L1_LO:  r_l1_lo <= RD_in;
        ACC_L1_HI:  begin l1_data <= {RD_in, r_l1_lo}; l1_valid <= 1'b1; end
        ACC_CPU_RD: begin cpu_rdata <= RD_in; cpu_ack <= 1'b1; end
        ACC_CPU_WR: cpu_ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
